// File: rtl/proc_pkg.sv
// Shared encodings for the proc_mc micro-controller: opcodes, branch
// conditions, PSR bit positions and the controller FSM state.
package proc_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LD  = 4'd1,
        OP_STR = 4'd2,
        OP_BRA = 4'd3,
        OP_XOR = 4'd4,
        OP_ADD = 4'd5,
        OP_ROT = 4'd6,
        OP_SHF = 4'd7,
        OP_HLT = 4'd8,
        OP_CMP = 4'd9
    } opcode_e;

    localparam logic [2:0] BR_ALWAYS = 3'd0;
    localparam logic [2:0] BR_P      = 3'd1;
    localparam logic [2:0] BR_E      = 3'd2;
    localparam logic [2:0] BR_C      = 3'd3;
    localparam logic [2:0] BR_N      = 3'd4;
    localparam logic [2:0] BR_Z      = 3'd5;
    localparam logic [2:0] BR_NC     = 3'd6;
    localparam logic [2:0] BR_GT     = 3'd7;

    localparam int PSR_C = 0;
    localparam int PSR_P = 1;
    localparam int PSR_E = 2;
    localparam int PSR_N = 3;
    localparam int PSR_Z = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2,
        ST_HALT = 2'd3
    } state_e;

endpackage

// File: rtl/proc_alu.sv
// Combinational execute unit: computes the result, register/PSR write
// enables, the new PSR and the branch decision for one instruction.
module proc_alu
    import proc_pkg::*;
#(
    parameter int BUSW = 32,
    parameter int IMMW = 12
) (
    input  logic [3:0]      op,
    input  logic [BUSW-1:0] dst_val,
    input  logic [BUSW-1:0] src_val,
    input  logic [IMMW-1:0] cnt,
    input  logic [4:0]      psr_in,
    output logic [BUSW-1:0] result,
    output logic            wr_en,
    output logic            psr_we,
    output logic [4:0]      psr_out,
    output logic            br_taken,
    output logic            illegal
);

    localparam logic [31:0] BUSW_U = 32'(BUSW);

    logic            cnt_neg;
    logic [IMMW-1:0] mag;
    logic [31:0]     mag_w;
    logic [31:0]     rot_amt;
    logic [BUSW:0]   sum;
    logic [BUSW:0]   shl_ext;
    logic [BUSW:0]   shr_ext;
    logic [BUSW-1:0] rotl;
    logic [BUSW-1:0] rotr;
    logic            carry;
    logic            cond;

    // Count is two's complement; magnitude of the most negative value still fits unsigned.
    always_comb begin
        cnt_neg = cnt[IMMW-1];
        mag     = cnt_neg ? (~cnt + IMMW'(1)) : cnt;
        mag_w   = 32'(mag);
        rot_amt = mag_w % BUSW_U;
        sum     = {1'b0, dst_val} + {1'b0, src_val};
        // One guard bit catches the last bit shifted out on either side.
        shl_ext = {1'b0, dst_val} << mag;
        shr_ext = {dst_val, 1'b0} >> mag;
        rotl    = (dst_val << rot_amt) | (dst_val >> (BUSW_U - rot_amt));
        rotr    = (dst_val >> rot_amt) | (dst_val << (BUSW_U - rot_amt));
    end

    always_comb begin
        case (cnt[2:0])
            BR_ALWAYS: cond = 1'b1;
            BR_P:      cond = psr_in[PSR_P];
            BR_E:      cond = psr_in[PSR_E];
            BR_C:      cond = psr_in[PSR_C];
            BR_N:      cond = psr_in[PSR_N];
            BR_Z:      cond = psr_in[PSR_Z];
            BR_NC:     cond = ~psr_in[PSR_C];
            BR_GT:     cond = ~psr_in[PSR_N] & ~psr_in[PSR_Z];
            default:   cond = 1'b0;
        endcase
    end

    always_comb begin
        result   = '0;
        wr_en    = 1'b0;
        psr_we   = 1'b0;
        carry    = 1'b0;
        br_taken = 1'b0;
        illegal  = 1'b0;
        case (op)
            OP_NOP, OP_HLT: ;
            OP_LD:  begin result = src_val;           wr_en = 1'b1; psr_we = 1'b1; end
            OP_STR: begin result = dst_val;                         psr_we = 1'b1; end
            OP_BRA: br_taken = cond;
            OP_XOR: begin result = dst_val ^ src_val; wr_en = 1'b1; psr_we = 1'b1; end
            OP_ADD: begin
                result = sum[BUSW-1:0];
                carry  = sum[BUSW];
                wr_en  = 1'b1;
                psr_we = 1'b1;
            end
            OP_ROT: begin
                wr_en  = 1'b1;
                psr_we = 1'b1;
                if (mag_w == 32'd0) begin
                    result = dst_val;
                end else if (!cnt_neg) begin
                    result = rotl;
                    carry  = rotl[0];
                end else begin
                    result = rotr;
                    carry  = rotr[BUSW-1];
                end
            end
            OP_SHF: begin
                wr_en  = 1'b1;
                psr_we = 1'b1;
                if (mag_w == 32'd0) begin
                    result = dst_val;
                end else if (mag_w >= BUSW_U) begin
                    result = '0;
                end else if (!cnt_neg) begin
                    result = shl_ext[BUSW-1:0];
                    carry  = shl_ext[BUSW];
                end else begin
                    result = shr_ext[BUSW:1];
                    carry  = shr_ext[0];
                end
            end
            OP_CMP: begin result = ~src_val;          wr_en = 1'b1; psr_we = 1'b1; end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        psr_out        = '0;
        psr_out[PSR_C] = carry;
        psr_out[PSR_P] = ~^result;
        psr_out[PSR_E] = ~result[0];
        psr_out[PSR_N] = result[BUSW-1];
        psr_out[PSR_Z] = (result == '0);
    end

endmodule

// File: rtl/proc_mc.sv
// Multi-cycle micro-controller: IDLE accepts, EXEC evaluates the ALU,
// WB commits register/PSR and pulses res_valid; HLT parks in HALT.
module proc_mc
    import proc_pkg::*;
#(
    parameter  int BUSW   = 32,
    parameter  int RWORDS = 16,
    parameter  int IMMW   = 12,
    parameter  int PSRW   = 5,
    localparam int RINDW  = $clog2(RWORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic             src_is_imm,
    input  logic [IMMW-1:0]  src_op,
    input  logic [RINDW-1:0] dst_op,
    output logic [BUSW-1:0]  res,
    output logic             res_valid,
    output logic [PSRW-1:0]  status,
    output logic             br_taken,
    output logic             halted,
    output logic             illegal
);

    state_e state_q, state_d;

    logic [3:0]                  op_q, op_d;
    logic [IMMW-1:0]             src_q, src_d;
    logic [RINDW-1:0]            dst_q, dst_d;
    logic                        imm_q, imm_d;
    logic [RWORDS-1:0][BUSW-1:0] regs_q, regs_d;
    logic [4:0]                  psr_q, psr_d;

    logic [BUSW-1:0] wb_res_q, wb_res_d;
    logic            wb_we_q, wb_we_d;
    logic            wb_psr_we_q, wb_psr_we_d;
    logic [4:0]      wb_psr_q, wb_psr_d;
    logic            wb_br_q, wb_br_d;
    logic            wb_ill_q, wb_ill_d;

    logic [BUSW-1:0] res_q, res_d;
    logic            res_valid_q, res_valid_d;
    logic            br_q, br_d;
    logic            ill_q, ill_d;

    logic [BUSW-1:0] dst_val, src_val, alu_res;
    logic            alu_we, alu_psr_we, alu_br, alu_ill;
    logic [4:0]      alu_psr;

    // Operands come from the pre-write register file, so dst==src reads the old value.
    assign dst_val = regs_q[dst_q];
    assign src_val = imm_q ? BUSW'(src_q) : regs_q[src_q[RINDW-1:0]];

    proc_alu #(.BUSW(BUSW), .IMMW(IMMW)) u_alu (
        .op       (op_q),
        .dst_val  (dst_val),
        .src_val  (src_val),
        .cnt      (src_q),
        .psr_in   (psr_q),
        .result   (alu_res),
        .wr_en    (alu_we),
        .psr_we   (alu_psr_we),
        .psr_out  (alu_psr),
        .br_taken (alu_br),
        .illegal  (alu_ill)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = (op_q == OP_HLT) ? ST_HALT : ST_IDLE;
            default: state_d = ST_HALT;
        endcase
    end

    always_comb begin
        in_ready = (state_q == ST_IDLE);
        halted   = (state_q == ST_HALT);
    end

    always_comb begin
        op_d        = op_q;
        src_d       = src_q;
        dst_d       = dst_q;
        imm_d       = imm_q;
        regs_d      = regs_q;
        psr_d       = psr_q;
        wb_res_d    = wb_res_q;
        wb_we_d     = wb_we_q;
        wb_psr_we_d = wb_psr_we_q;
        wb_psr_d    = wb_psr_q;
        wb_br_d     = wb_br_q;
        wb_ill_d    = wb_ill_q;
        res_d       = res_q;
        res_valid_d = 1'b0;
        br_d        = 1'b0;
        ill_d       = 1'b0;
        if (state_q == ST_IDLE && in_valid) begin
            op_d  = opcode;
            src_d = src_op;
            dst_d = dst_op;
            imm_d = src_is_imm;
        end
        if (state_q == ST_EXEC) begin
            wb_res_d    = alu_res;
            wb_we_d     = alu_we;
            wb_psr_we_d = alu_psr_we;
            wb_psr_d    = alu_psr;
            wb_br_d     = alu_br;
            wb_ill_d    = alu_ill;
        end
        if (state_q == ST_WB) begin
            if (wb_we_q)     regs_d[dst_q] = wb_res_q;
            if (wb_psr_we_q) psr_d = wb_psr_q;
            res_d       = wb_res_q;
            res_valid_d = 1'b1;
            br_d        = wb_br_q;
            ill_d       = wb_ill_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q        <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            imm_q       <= 1'b0;
            regs_q      <= '0;
            psr_q       <= '0;
            wb_res_q    <= '0;
            wb_we_q     <= 1'b0;
            wb_psr_we_q <= 1'b0;
            wb_psr_q    <= '0;
            wb_br_q     <= 1'b0;
            wb_ill_q    <= 1'b0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            br_q        <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            op_q        <= op_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            imm_q       <= imm_d;
            regs_q      <= regs_d;
            psr_q       <= psr_d;
            wb_res_q    <= wb_res_d;
            wb_we_q     <= wb_we_d;
            wb_psr_we_q <= wb_psr_we_d;
            wb_psr_q    <= wb_psr_d;
            wb_br_q     <= wb_br_d;
            wb_ill_q    <= wb_ill_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            br_q        <= br_d;
            ill_q       <= ill_d;
        end
    end

    assign res       = res_q;
    assign res_valid = res_valid_q;
    assign br_taken  = br_q;
    assign illegal   = ill_q;
    assign status    = PSRW'(psr_q);

endmodule

// File: tb/tb_proc_mc.sv
// Self-checking bench for proc_mc: directed scenarios plus random
// instruction streams checked against a behavioural model.
module tb_proc_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic        src_is_imm;
    logic [11:0] src_op;
    logic [3:0]  dst_op;
    logic [31:0] res;
    logic        res_valid;
    logic [4:0]  status;
    logic        br_taken;
    logic        halted;
    logic        illegal;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    proc_mc dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .src_is_imm (src_is_imm),
        .src_op     (src_op),
        .dst_op     (dst_op),
        .res        (res),
        .res_valid  (res_valid),
        .status     (status),
        .br_taken   (br_taken),
        .halted     (halted),
        .illegal    (illegal)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: register file and PSR {Z,N,E,P,C}.
    logic [31:0] mregs [16];
    logic [4:0]  mpsr;
    logic [31:0] e_res;
    logic        e_br, e_ill;

    logic [31:0] g_res;
    logic [4:0]  g_st;
    logic        g_br, g_ill;
    int          g_lat, g_acc;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mregs[i] = '0;
        mpsr = '0;
    endtask

    task automatic model(input logic [3:0] op, input logic imm, input logic [11:0] s, input logic [3:0] d);
        logic [31:0] sv, dv, r;
        logic [32:0] t;
        logic        c, wr, upd;
        int          cnt, mag;
        sv = imm ? {20'd0, s} : mregs[s[3:0]];
        dv = mregs[d];
        r = '0; c = 1'b0; wr = 1'b0; upd = 1'b0; e_br = 1'b0; e_ill = 1'b0;
        cnt = int'($signed(s));
        mag = (cnt < 0) ? -cnt : cnt;
        case (op)
            4'd0, 4'd8: ;
            4'd1: begin r = sv; wr = 1; upd = 1; end
            4'd2: begin r = dv; upd = 1; end
            4'd3: case (s[2:0])
                3'd0: e_br = 1'b1;
                3'd1: e_br = mpsr[1];
                3'd2: e_br = mpsr[2];
                3'd3: e_br = mpsr[0];
                3'd4: e_br = mpsr[3];
                3'd5: e_br = mpsr[4];
                3'd6: e_br = !mpsr[0];
                default: e_br = !mpsr[3] && !mpsr[4];
            endcase
            4'd4: begin r = dv ^ sv; wr = 1; upd = 1; end
            4'd5: begin t = 33'(dv) + 33'(sv); r = t[31:0]; c = t[32]; wr = 1; upd = 1; end
            4'd6: begin
                r = dv;
                for (int i = 0; i < mag; i++) begin
                    if (cnt > 0) begin c = r[31]; r = {r[30:0], r[31]}; end
                    else         begin c = r[0];  r = {r[0], r[31:1]};  end
                end
                wr = 1; upd = 1;
            end
            4'd7: begin
                if (mag >= 32)     r = '0;
                else if (cnt > 0)  begin r = dv << mag; c = dv[32-mag]; end
                else if (cnt < 0)  begin r = dv >> mag; c = dv[mag-1]; end
                else               r = dv;
                wr = 1; upd = 1;
            end
            4'd9: begin r = ~sv; wr = 1; upd = 1; end
            default: e_ill = 1'b1;
        endcase
        if (wr) mregs[d] = r;
        if (upd) mpsr = {r == 0, r[31], ~r[0], ($countones(r) % 2) == 0, c};
        e_res = r;
    endtask

    // Issue one instruction from a non-edge time, capture the WB outputs.
    task automatic exec(input logic [3:0] op, input logic imm, input logic [11:0] s, input logic [3:0] d);
        opcode = op; src_is_imm = imm; src_op = s; dst_op = d; in_valid = 1'b1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        g_acc = cyc;
        model(op, imm, s, d);
        n_cmp++;
        if (res_valid !== 1'b0) begin
            n_bad++; $display("FAIL valid_pulse_width: res_valid=%b at accept required 0", res_valid);
        end
        g_lat = 0;
        while (res_valid !== 1'b1 && g_lat < 8) begin
            @(posedge clk); #1;
            g_lat++;
        end
        g_res = res; g_st = status; g_br = br_taken; g_ill = illegal;
        n_cmp++;
        if (res_valid !== 1'b1 || g_lat != 2) begin
            n_bad++; $display("FAIL latency: op=%0d lat=%0d valid=%b required lat 2", op, g_lat, res_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; opcode = '0; src_is_imm = 1'b0; src_op = '0; dst_op = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1;
        n_cmp++;
        if ({res, res_valid, br_taken, illegal, halted, in_ready, status} !== {32'd0, 5'b00001, 5'd0}) begin
            n_bad++;
            $display("FAIL reset_state: res=%h v=%b br=%b ill=%b h=%b rdy=%b st=%b required all 0, rdy=1",
                     res, res_valid, br_taken, illegal, halted, in_ready, status);
        end
    endtask

    task automatic test_ld_add();
        exec(4'd1, 1'b1, 12'h7FF, 4'd1);
        n_cmp++;
        if (g_res !== 32'h7FF) begin n_bad++; $display("FAIL ld_res: %h required 000007ff", g_res); end
        exec(4'd5, 1'b1, 12'h001, 4'd1);
        n_cmp++;
        if (g_res !== 32'h800 || g_st !== 5'b00100) begin
            n_bad++; $display("FAIL add_800: res=%h st=%b required 00000800 00100", g_res, g_st);
        end
    endtask

    task automatic test_cmp_carry();
        exec(4'd1, 1'b1, 12'hFFF, 4'd2);
        exec(4'd9, 1'b0, 12'd2, 4'd3);
        n_cmp++;
        if (g_res !== 32'hFFFFF000 || g_st !== 5'b01110) begin
            n_bad++; $display("FAIL cmp: res=%h st=%b required fffff000 01110", g_res, g_st);
        end
        // 0x1000 exceeds the 12-bit immediate, so build it in r9 first.
        exec(4'd1, 1'b1, 12'h800, 4'd9);
        exec(4'd5, 1'b0, 12'd9, 4'd9);
        n_cmp++;
        if (g_res !== 32'h1000) begin n_bad++; $display("FAIL add_self: res=%h required 00001000", g_res); end
        exec(4'd5, 1'b0, 12'd9, 4'd3);
        n_cmp++;
        if (g_res !== 32'h0 || g_st !== 5'b10111) begin
            n_bad++; $display("FAIL add_carry: res=%h st=%b required 00000000 10111", g_res, g_st);
        end
    endtask

    task automatic test_rot_shf();
        exec(4'd1, 1'b1, 12'h001, 4'd4);
        exec(4'd6, 1'b1, 12'hFFF, 4'd4);
        n_cmp++;
        if (g_res !== 32'h80000000 || g_st !== 5'b01101) begin
            n_bad++; $display("FAIL rot_m1: res=%h st=%b required 80000000 01101", g_res, g_st);
        end
        exec(4'd7, 1'b1, 12'h028, 4'd4);
        n_cmp++;
        if (g_res !== 32'h0 || g_st !== 5'b10110) begin
            n_bad++; $display("FAIL shf_40: res=%h st=%b required 00000000 10110", g_res, g_st);
        end
    endtask

    task automatic test_bra();
        exec(4'd1, 1'b1, 12'h000, 4'd7);
        exec(4'd3, 1'b1, 12'd5, 4'd0);
        n_cmp++;
        if (g_br !== 1'b1 || g_st !== 5'b10110 || g_res !== 32'h0) begin
            n_bad++; $display("FAIL bra_z: br=%b st=%b res=%h required 1 10110 0", g_br, g_st, g_res);
        end
        exec(4'd1, 1'b1, 12'hFFF, 4'd10);
        exec(4'd9, 1'b0, 12'd10, 4'd10);
        exec(4'd5, 1'b0, 12'd9, 4'd10);
        exec(4'd3, 1'b1, 12'd6, 4'd0);
        n_cmp++;
        if (g_br !== 1'b0 || g_st !== 5'b10111) begin
            n_bad++; $display("FAIL bra_nc: br=%b st=%b required 0 10111", g_br, g_st);
        end
        exec(4'd3, 1'b1, 12'd3, 4'd0);
        n_cmp++;
        if (g_br !== 1'b1) begin n_bad++; $display("FAIL bra_c: br=%b required 1", g_br); end
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [11:0] s;
        for (int i = 0; i < 120; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'd8) op = 4'd9;
            s = 12'($urandom);
            if ((op == 4'd6 || op == 4'd7) && $urandom_range(0, 1) == 1)
                s = 12'($urandom_range(0, 80) - 40);
            exec(op, 1'($urandom), s, 4'($urandom));
            n_cmp++;
            if (g_res !== e_res || g_st !== mpsr || g_br !== e_br || g_ill !== e_ill) begin
                n_bad++;
                $display("FAIL random op=%0d src=%h: res=%h st=%b br=%b ill=%b required %h %b %b %b",
                         op, s, g_res, g_st, g_br, g_ill, e_res, mpsr, e_br, e_ill);
            end
        end
        for (int r = 0; r < 16; r++) begin
            exec(4'd2, 1'b1, 12'd0, 4'(r));
            n_cmp++;
            if (g_res !== e_res) begin
                n_bad++; $display("FAIL regfile r%0d: %h required %h", r, g_res, e_res);
            end
        end
    endtask

    task automatic test_back_to_back();
        int prev;
        exec(4'd1, 1'b1, 12'h0AB, 4'd11);
        prev = g_acc;
        for (int i = 0; i < 5; i++) begin
            exec(4'd5, 1'b1, 12'(i + 1), 4'd11);
            n_cmp++;
            if (g_acc - prev != 3 || g_res !== e_res) begin
                n_bad++; $display("FAIL back_to_back: spacing=%0d res=%h required 3 %h", g_acc - prev, g_res, e_res);
            end
            prev = g_acc;
        end
    endtask

    task automatic test_reset_mid_exec();
        logic seen;
        exec(4'd1, 1'b1, 12'h077, 4'd5);
        opcode = 4'd5; src_is_imm = 1'b1; src_op = 12'd5; dst_op = 4'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        model_reset();
        seen = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1 || status !== 5'd0) begin
            n_bad++; $display("FAIL reset_mid_ready: rdy=%b st=%b required 1 00000", in_ready, status);
        end
        repeat (4) begin
            if (res_valid !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL reset_mid_novalid: res_valid seen=%b required 0", seen); end
        exec(4'd2, 1'b1, 12'd0, 4'd5);
        n_cmp++;
        if (g_res !== 32'h0 || g_st !== 5'b10110) begin
            n_bad++; $display("FAIL reset_mid_r5: res=%h st=%b required 00000000 10110", g_res, g_st);
        end
    endtask

    task automatic test_illegal_halt();
        logic [4:0] st0;
        int bad;
        exec(4'd1, 1'b1, 12'h123, 4'd6);
        st0 = g_st;
        exec(4'hC, 1'b1, 12'h005, 4'd6);
        n_cmp++;
        if (g_ill !== 1'b1 || g_res !== 32'h0 || g_st !== st0) begin
            n_bad++; $display("FAIL illegal: ill=%b res=%h st=%b required 1 0 %b", g_ill, g_res, g_st, st0);
        end
        exec(4'd2, 1'b1, 12'd0, 4'd6);
        n_cmp++;
        if (g_res !== 32'h123 || g_ill !== 1'b0) begin
            n_bad++; $display("FAIL illegal_noreg: res=%h ill=%b required 00000123 0", g_res, g_ill);
        end
        exec(4'd8, 1'b1, 12'd0, 4'd0);
        n_cmp++;
        if (halted !== 1'b1) begin n_bad++; $display("FAIL halt: halted=%b required 1", halted); end
        opcode = 4'd1; in_valid = 1'b1;
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (in_ready !== 1'b0 || halted !== 1'b1 || res_valid !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL halt_hold: %0d bad cycles required 0", bad); end
    endtask

    initial begin
        test_reset();
        test_ld_add();
        test_cmp_carry();
        test_rot_shf();
        test_bra();
        test_random();
        test_back_to_back();
        test_reset_mid_exec();
        test_illegal_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/proc_mc.md
PROC_MC -- requirements
Module: proc_mc

Interface
REQ-001 Parameter BUSW, default 32, SHALL set the data and register width in bits.
REQ-002 Parameter RWORDS, default 16, SHALL set the register count; it SHALL be a power of two, with RINDW=clog2(RWORDS).
REQ-003 Parameter IMMW, default 12, SHALL set the immediate/source-field width; IMMW<=BUSW.
REQ-004 Parameter PSRW, default 5, SHALL set the status width; PSRW>=5, and bits above 4 SHALL read 0.
REQ-005 clk  in  1  clock; one clock, and all state SHALL update on its rising edge.
REQ-006 rst  in  1  reset; asynchronous and active-high.
REQ-007 in_valid  in  1  instruction present; in_ready  out  1  block can accept.
REQ-008 opcode  in  4  operation; src_is_imm  in  1  src_op is an immediate.
REQ-009 src_op  in  IMMW  source register index (low RINDW bits), immediate value, signed shift/rotate count, or BRA condition in bits [2:0].
REQ-010 dst_op  in  RINDW  destination register index.
REQ-011 res  out  BUSW  instruction result; res_valid  out  1  one-cycle pulse qualifying res.
REQ-012 status  out  PSRW  PSR: bit0 C (carry), bit1 P (parity), bit2 E (even), bit3 N (negative), bit4 Z (zero).
REQ-013 br_taken  out  1  BRA condition true, qualified by res_valid; halted  out  1  HLT executed; illegal  out  1  unknown opcode, qualified by res_valid.

Function
REQ-014 The FSM SHALL have states IDLE, EXEC, WB and HALT; in_ready SHALL be 1 only in IDLE.
REQ-015 In IDLE, in_valid=1 SHALL latch opcode, src_op, dst_op and src_is_imm and go to EXEC; otherwise the FSM SHALL stay in IDLE.
REQ-016 In EXEC the block SHALL read operands and compute the result, then go to WB; in WB it SHALL write the register and PSR, pulse res_valid, and return to IDLE, or go to HALT for HLT.
REQ-017 Latency SHALL be res_valid exactly 2 cycles after the accepting edge; throughput SHALL be one instruction per 3 cycles.
REQ-018 src value SHALL be the immediate zero-extended to BUSW if src_is_imm, otherwise reg[src_op[RINDW-1:0]].
REQ-019 Opcodes SHALL be: NOP=0 no effect, res=0. LD=1: reg[dst]=src. STR=2: res=reg[dst], no register write. BRA=3: no write, res=0. XOR=4: reg[dst]^=src. ADD=5: reg[dst]+=src, modulo 2^BUSW. ROT=6: rotate reg[dst]. SHF=7: logical shift reg[dst]. HLT=8. CMP=9: reg[dst]=~src.
REQ-020 For ROT/SHF, src_op SHALL be a signed two's-complement count and src_is_imm SHALL be ignored: positive shifts/rotates left, negative right, zero leaves the value unchanged.
REQ-021 ROT SHALL use the count magnitude modulo BUSW; SHF with magnitude >= BUSW SHALL yield 0 with C=0.
REQ-022 res SHALL equal the written or read value for LD/STR/XOR/ADD/ROT/SHF/CMP.
REQ-023 Z=(res==0), N=res[BUSW-1], E=~res[0], P=~^res (1 for an even count of ones).
REQ-024 C SHALL be the ADD carry-out, or the last bit shifted/rotated out for SHF/ROT (0 for a zero count); C SHALL be cleared for LD/STR/XOR/CMP.
REQ-025 NOP, BRA, HLT and illegal opcodes SHALL leave the PSR unchanged.
REQ-026 BRA conditions SHALL be: 0 always, 1 P, 2 E, 3 C, 4 N, 5 Z, 6 ~C, 7 ~N&~Z, evaluated on the PSR before the instruction.
REQ-027 Opcodes 10-15 SHALL execute as NOP with illegal=1 during the res_valid pulse.
REQ-028 In HALT, halted SHALL be 1, in_ready SHALL be 0, and the block SHALL exit only by reset.
REQ-029 When dst equals src, the operand SHALL be the pre-write value.

Reset
REQ-030 rst SHALL force IDLE, zero all registers and status, and drive res=0, res_valid=0, br_taken=0, illegal=0, halted=0 and in_ready=1 after release.
REQ-031 rst asserted in EXEC or WB SHALL discard the instruction with no register or PSR write.

Structure
REQ-032 Package proc_pkg SHALL hold the opcode enum, BRA condition codes, PSR bit indices and the FSM state typedef.
REQ-033 Combinational sub-module proc_alu (operation, operands, and carry/flag generation) SHALL be instantiated once; the register file and FSM SHALL live in proc_mc.

Verification
REQ-034 LD r1 #0x7FF, then ADD r1 #1 -> res=0x800, Z=0, N=0, C=0, res_valid 2 cycles after accept.
REQ-035 LD r2 #0xFFF, CMP r3 r2, ADD r3 #0x1000 -> r3=0xFFFFF000 then 0x00000000, C=1, Z=1, P=1, E=1.
REQ-036 LD r4 #1, ROT r4 #-1 -> 0x80000000, N=1, C=1; SHF r4 #40 (0x028) -> 0, C=0, Z=1.
REQ-037 Z=1 then BRA cond 5 -> br_taken=1; BRA cond 6 with C=1 -> br_taken=0; PSR unchanged by both.
REQ-038 opcode 0xC -> illegal=1, PSR and registers unchanged; HLT -> halted=1, in_ready stays 0 for 10 cycles with in_valid=1.
REQ-039 rst pulsed mid-EXEC of ADD r5 #5 -> no res_valid, r5=0, status=0, in_ready=1 on the next cycle.
